phase_sequencer: RTL and testbench

//  Parametrised instruction-phase sequencer for the multi-cycle core. Emits a one-hot

---
 rtl/phase_seq_pkg.sv | 13 +
 rtl/phase_ring.sv | 21 ++
 rtl/phase_sequencer.sv | 71 +++++++
 tb/tb_phase_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg: shared state encoding and default phase count for the phase sequencer
package phase_seq_pkg;

   typedef enum logic [1:0] {
      ST_STOP   = 2'b00,
      ST_RUN    = 2'b01,
      ST_STEP_I = 2'b10,
      ST_STEP_P = 2'b11
   } state_t;

   localparam int NPHASE_DEFAULT = 4;

endpackage

// File: rtl/phase_ring.sv
// phase_ring: one-hot phase register that rotates on en and flags the wrap back to phase 0
module phase_ring
   import phase_seq_pkg::*;
#(
   parameter int NPHASE = NPHASE_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   output logic [NPHASE-1:0] cstate,
   output logic              wrap
);

   // rotate left on enable; the last phase wraps back to bit 0
   always_ff @(posedge clock or negedge reset)
      if (!reset) cstate <= NPHASE'(1);
      else if (en) cstate <= {cstate[NPHASE-2:0], cstate[NPHASE-1]};

   assign wrap = en & cstate[NPHASE-1];

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: run/step control FSM driving a one-hot phase ring; PHASESEQ_ICOUNT_EN adds the retired-instruction counter
module phase_sequencer
   import phase_seq_pkg::*;
#(
   parameter int NPHASE = NPHASE_DEFAULT
`ifdef PHASESEQ_ICOUNT_EN
   , parameter int ICNT_W = 32
`endif
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              step_phase,
   input  logic              step_inst,
   input  logic              stall,
   input  logic              halt,
   output logic [NPHASE-1:0] cstate,
   output logic              running,
   output logic              inst_done
`ifdef PHASESEQ_ICOUNT_EN
   , output logic [ICNT_W-1:0] icount
`endif
);

   state_t state, next;
   logic   adv, wrap;

   phase_ring #(.NPHASE(NPHASE)) u_ring (
      .clock  (clock),
      .reset  (reset),
      .en     (adv),
      .cstate (cstate),
      .wrap   (wrap)
   );

   // control state register
   always_ff @(posedge clock or negedge reset)
      if (!reset) state <= ST_STOP;
      else state <= next;

   // next state and advance: halt beats stall, stall freezes everything, run stops RUN without advancing
   always_comb begin
      next = state;
      adv  = 1'b0;
      if (state == ST_STOP)
         next = run ? ST_RUN : step_phase ? ST_STEP_P : step_inst ? ST_STEP_I : ST_STOP;
      else if (halt) begin
         next = ST_STOP;
         adv  = !stall;
      end else if (!stall) begin
         adv  = !(state == ST_RUN && run);
         next = state == ST_RUN ? (run ? ST_STOP : ST_RUN)
              : (state == ST_STEP_I && !cstate[NPHASE-1]) ? ST_STEP_I : ST_STOP;
      end
   end

   // instruction-done pulse follows the wrapping edge for one cycle
   always_ff @(posedge clock or negedge reset)
      if (!reset) inst_done <= 1'b0;
      else inst_done <= wrap;

`ifdef PHASESEQ_ICOUNT_EN
   // count retired instructions on every wrapping edge
   always_ff @(posedge clock or negedge reset)
      if (!reset) icount <= '0;
      else if (wrap) icount <= icount + ICNT_W'(1);
`endif

   assign running = state != ST_STOP;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: scoreboard bench for phase_sequencer (NPHASE=4 main instance, NPHASE=5 counter instance)
module tb_phase_sequencer;

   typedef struct {
      string      nm;
      logic [4:0] cs;
      logic       rn;
      logic       dn;
      int         ic;
   } exp_t;

   localparam logic [4:0] N  = 5'b00000;
   localparam logic [4:0] R  = 5'b10000;
   localparam logic [4:0] SP = 5'b01000;
   localparam logic [4:0] SI = 5'b00100;
   localparam logic [4:0] ST = 5'b00010;
   localparam logic [4:0] H  = 5'b00001;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0, step_phase = 1'b0, step_inst = 1'b0, stall = 1'b0, halt = 1'b0;
   logic       run5 = 1'b0, zero = 1'b0;
   logic [3:0] cstate;
   logic [4:0] cstate5;
   logic       running, inst_done, running5, inst_done5;
`ifdef PHASESEQ_ICOUNT_EN
   logic [31:0] icount, icount5;
`endif

   exp_t q[$];
   exp_t q5[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   phase_sequencer dut (
      .clock(clock), .reset(reset), .run(run), .step_phase(step_phase),
      .step_inst(step_inst), .stall(stall), .halt(halt),
      .cstate(cstate), .running(running), .inst_done(inst_done)
`ifdef PHASESEQ_ICOUNT_EN
      , .icount(icount)
`endif
   );

   phase_sequencer #(.NPHASE(5)) dut5 (
      .clock(clock), .reset(reset), .run(run5), .step_phase(zero),
      .step_inst(zero), .stall(zero), .halt(zero),
      .cstate(cstate5), .running(running5), .inst_done(inst_done5)
`ifdef PHASESEQ_ICOUNT_EN
      , .icount(icount5)
`endif
   );

   // monitor: compare the oldest pending expectation against the outputs at the falling edge
   always @(negedge clock) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if ({cstate, running, inst_done} !== {e.cs[3:0], e.rn, e.dn}) begin
            failures++;
            $display("FAIL %s: got cstate=%b running=%b inst_done=%b, want cstate=%b running=%b inst_done=%b",
                     e.nm, cstate, running, inst_done, e.cs[3:0], e.rn, e.dn);
         end
      end
      if (q5.size() > 0) begin
         exp_t e;
         e = q5.pop_front();
         checks++;
         if ({cstate5, running5, inst_done5} !== {e.cs, e.rn, e.dn}) begin
            failures++;
            $display("FAIL %s: got cstate=%b running=%b inst_done=%b, want cstate=%b running=%b inst_done=%b",
                     e.nm, cstate5, running5, inst_done5, e.cs, e.rn, e.dn);
         end
`ifdef PHASESEQ_ICOUNT_EN
         checks++;
         if (icount5 !== 32'(e.ic)) begin
            failures++;
            $display("FAIL %s_icount: got %0d, want %0d", e.nm, icount5, e.ic);
         end
`endif
      end
   end

   task automatic push(input string nm, input logic [4:0] cs, input logic rn, input logic dn);
      exp_t e;
      e.nm = nm; e.cs = cs; e.rn = rn; e.dn = dn; e.ic = 0;
      q.push_back(e);
   endtask

   task automatic step(input string nm, input logic [4:0] cmd, input logic [3:0] cs,
                       input logic rn, input logic dn, input bit chk = 1'b1);
      {run, step_phase, step_inst, stall, halt} = cmd;
      @(posedge clock); #1;
      {run, step_phase, step_inst, stall, halt} = N;
      if (chk) push(nm, {1'b0, cs}, rn, dn);
   endtask

   task automatic step5(input string nm, input logic r, input logic [4:0] cs,
                        input logic rn, input logic dn, input int ic);
      exp_t e;
      run5 = r;
      @(posedge clock); #1;
      run5 = 1'b0;
      e.nm = nm; e.cs = cs; e.rn = rn; e.dn = dn; e.ic = ic;
      q5.push_back(e);
   endtask

   initial begin
      #1;
      push("reset_init", 5'b00001, 1'b0, 1'b0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b1;
      // free run: two wraps, then stop without advancing
      step("run_start", R, 4'b0001, 1, 0);
      for (int i = 1; i <= 9; i++)
         step("run_adv", N, 4'(1 << (i % 4)), 1, (i % 4) == 0);
      step("run_stop", R, 4'b0010, 0, 0);
      // step_inst from mid-instruction finishes it only; step_phase during it is ignored
      step("si_start", SI, 4'b0010, 1, 0);
      step("si_adv", N, 4'b0100, 1, 0);
      step("si_ign_sp", SP, 4'b1000, 1, 0);
      step("si_wrap", N, 4'b0001, 0, 1);
      step("si_idle", N, 4'b0001, 0, 0);
      // single phase step, then a full instruction step
      step("sp_start", SP, 4'b0001, 1, 0);
      step("sp_adv", N, 4'b0010, 0, 0);
      step("sp_hold", N, 4'b0010, 0, 0);
      step("si2_start", SI, 4'b0010, 1, 0);
      step("si2_a", N, 4'b0100, 1, 0);
      step("si2_b", N, 4'b1000, 1, 0);
      step("si2_wrap", N, 4'b0001, 0, 1);
      // stall holds phase and swallows a run pulse
      step("r4_start", R, 4'b0001, 1, 0);
      step("r4_a", N, 4'b0010, 1, 0);
      step("r4_b", N, 4'b0100, 1, 0);
      step("stall1", ST, 4'b0100, 1, 0);
      step("stall_run", ST | R, 4'b0100, 1, 0);
      step("stall3", ST, 4'b0100, 1, 0);
      step("stall_release", N, 4'b1000, 1, 0);
      step("r4_wrap", N, 4'b0001, 1, 1);
      step("r4_c", N, 4'b0010, 1, 0);
      // halt completes the phase and stops; halt beats run; halt ignored in STOP
      step("halt", H, 4'b0100, 0, 0);
      step("r5_start", R, 4'b0100, 1, 0);
      step("halt_run", H | R, 4'b1000, 0, 0);
      step("halt_in_stop", H, 4'b1000, 0, 0);
      step("stall_in_stop", ST, 4'b1000, 0, 0);
      step("r6_start", R, 4'b1000, 1, 0);
      step("halt_stall", H | ST, 4'b1000, 0, 0);
      step("r7_start", R, 4'b1000, 1, 0);
      step("halt_wrap", H, 4'b0001, 0, 1);
      // asynchronous reset right after a wrapping edge
      step("r8_start", R, 4'b0001, 1, 0);
      step("r8_a", N, 4'b0010, 1, 0);
      step("r8_b", N, 4'b0100, 1, 0);
      step("r8_c", N, 4'b1000, 1, 0);
      step("r8_wrap", N, 4'b0001, 1, 1, 1'b0);
      reset = 1'b0;
      push("async_reset", 5'b00001, 1'b0, 1'b0);
      step("reset_held", R, 4'b0001, 0, 0);
      reset = 1'b1;
      step("post_reset", N, 4'b0001, 0, 0);
      // five-phase instance: three instructions in RUN
      step5("n5_start", 1'b1, 5'b00001, 1, 0, 0);
      for (int k = 1; k <= 15; k++)
         step5("n5_adv", 1'b0, 5'(1 << (k % 5)), 1, (k % 5) == 0, k / 5);
      step5("n5_stop", 1'b1, 5'b00001, 0, 0, 3);
      @(negedge clock); #1;
      checks++;
      if (q.size() != 0 || q5.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending, want 0", q.size() + q5.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
